path_tracer: RTL and testbench

Walks the converged direction field of the node execution unit grid backward from a goal cell to the source cell. It emits one grid coordinate per step over a valid/ready stream, goal first and source last. It sits downstream of the neu array: it addresses one node at a time through the grid read mux and consumes that node's `path_cost` and `path_dir`. It is started by the controller once no node reports `path_mod`.

---
 rtl/path_tracer.sv | 148 ++++++++++++++
 tb/tb_path_tracer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/path_tracer.sv
// Walks the converged direction field backward from the goal cell to the source cell,
// emitting one coordinate per step on a valid/ready stream (goal first, source last).
// Ports: start/goal/src in; rd_x/rd_y out + rd_cost/rd_dir in (grid read mux);
//        out_valid/out_ready/out_x/out_y/out_last stream; busy, done, err status.
module path_tracer #(
  parameter int W         = 8,
  parameter int H         = 8,
  parameter int MAX_STEPS = 64,
  localparam int XW = $clog2(W),
  localparam int YW = $clog2(H),
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] goal_x,
  input  logic [YW-1:0] goal_y,
  input  logic [XW-1:0] src_x,
  input  logic [YW-1:0] src_y,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [11:0]   rd_cost,
  input  logic [2:0]    rd_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOOK, EMIT} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] cur_x, src_xq, nxt_x;
  logic [YW-1:0] cur_y, src_yq, nxt_y;
  logic [2:0]    dir_q;
  logic [SW-1:0] step_cnt;

  logic load, take_dir, advance, done_nxt, err_nxt;
  logic at_src, east, west, north, south, off_grid;

  assign at_src = (cur_x == src_xq) && (cur_y == src_yq);

  // Direction components: 0=N,1=NE,2=E,3=SE,4=S,5=SW,6=W,7=NW; N is y-1.
  assign east  = (dir_q == 3'd1) || (dir_q == 3'd2) || (dir_q == 3'd3);
  assign west  = (dir_q == 3'd5) || (dir_q == 3'd6) || (dir_q == 3'd7);
  assign north = (dir_q == 3'd7) || (dir_q == 3'd0) || (dir_q == 3'd1);
  assign south = (dir_q == 3'd3) || (dir_q == 3'd4) || (dir_q == 3'd5);

  assign off_grid = (west  && (cur_x == '0))             ||
                    (east  && (cur_x == XW'(W - 1)))     ||
                    (north && (cur_y == '0))             ||
                    (south && (cur_y == YW'(H - 1)));

  assign nxt_x = east  ? cur_x + XW'(1) : (west  ? cur_x - XW'(1) : cur_x);
  assign nxt_y = south ? cur_y + YW'(1) : (north ? cur_y - YW'(1) : cur_y);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    take_dir  = 1'b0;
    advance   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = LOOK;
        end
      end
      LOOK: begin
        if (rd_cost == 12'hFFF) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          take_dir  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (at_src) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (step_cnt == SW'(MAX_STEPS - 1)) begin
            // Step budget exhausted: the field has a loop.
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else if (off_grid) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = LOOK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x    <= '0;
      cur_y    <= '0;
      src_xq   <= '0;
      src_yq   <= '0;
      dir_q    <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= done_nxt;
      err  <= err_nxt;
      if (load) begin
        cur_x    <= goal_x;
        cur_y    <= goal_y;
        src_xq   <= src_x;
        src_yq   <= src_y;
        step_cnt <= '0;
      end
      if (take_dir) dir_q <= rd_dir;
      if (advance) begin
        cur_x    <= nxt_x;
        cur_y    <= nxt_y;
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

  assign rd_x      = cur_x;
  assign rd_y      = cur_y;
  assign out_x     = cur_x;
  assign out_y     = cur_y;
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && at_src;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_path_tracer.sv
module tb_path_tracer;

  localparam int MAXS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  goal_x = '0, goal_y = '0, src_x = '0, src_y = '0;
  logic [2:0]  rd_x, rd_y, out_x, out_y;
  logic [11:0] rd_cost;
  logic [2:0]  rd_dir;
  logic        out_valid, out_ready = 1'b0, out_last, busy, done, err;

  logic [11:0] cost_mem [8][8];
  logic [2:0]  dir_mem  [8][8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_cost = cost_mem[rd_y][rd_x];
  assign rd_dir  = dir_mem[rd_y][rd_x];

  path_tracer dut (
    .clk(clk), .rst(rst), .start(start),
    .goal_x(goal_x), .goal_y(goal_y), .src_x(src_x), .src_y(src_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cost(rd_cost), .rd_dir(rd_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack(input int x, input int y, input int last);
    return (x << 8) | (y << 4) | last;
  endfunction

  task automatic clear_grid();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        cost_mem[y][x] = 12'd1;
        dir_mem[y][x]  = 3'd0;
      end
  endtask

  // Reference: follow the direction field from the goal using the walk rules,
  // then drive the DUT and compare the accepted stream and final status.
  task automatic run_walk(input int gx, input int gy, input int sx, input int sy,
                          input int rdy_pct, input bit poke);
    int qc[$];
    int x, y, steps, nx, ny, dx, dy, n, exp_cyc, cyc, idx, saved;
    bit exp_err, look_err, finished, rdy, hold;
    x = gx; y = gy; steps = 0; exp_err = 0; look_err = 0;
    forever begin
      if (cost_mem[y][x] == 12'hFFF) begin exp_err = 1; look_err = 1; break; end
      qc.push_back(pack(x, y, (x == sx && y == sy) ? 1 : 0));
      if (x == sx && y == sy) break;
      if (steps == MAXS - 1) begin exp_err = 1; break; end
      case (dir_mem[y][x])
        3'd0: begin dx = 0;  dy = -1; end
        3'd1: begin dx = 1;  dy = -1; end
        3'd2: begin dx = 1;  dy = 0;  end
        3'd3: begin dx = 1;  dy = 1;  end
        3'd4: begin dx = 0;  dy = 1;  end
        3'd5: begin dx = -1; dy = 1;  end
        3'd6: begin dx = -1; dy = 0;  end
        default: begin dx = -1; dy = -1; end
      endcase
      nx = x + dx; ny = y + dy;
      if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin exp_err = 1; break; end
      x = nx; y = ny; steps++;
    end
    n = qc.size();
    exp_cyc = look_err ? 2 * n + 2 : 2 * n + 1;

    @(negedge clk);
    goal_x = gx[2:0]; goal_y = gy[2:0]; src_x = sx[2:0]; src_y = sy[2:0];
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; idx = 0; hold = 0; finished = 0; saved = 0;
    check("busy_after_start", busy, 1);
    while (!finished && cyc < 400) begin
      start = 1'b0;
      if (poke && cyc == 3 && busy) begin
        goal_x = 3'd7; goal_y = 3'd7; src_x = 3'd6; src_y = 3'd6; start = 1'b1;
      end
      if (hold) check("hold", {out_valid, pack(out_x, out_y, out_last)}, {1'b1, saved});
      if (done || err) begin
        check("end_is_err", err, exp_err);
        check("done_err_excl", done & err, 0);
        check("coord_count", idx, n);
        if (rdy_pct >= 100) check("end_cycle", cyc, exp_cyc);
        out_ready = 1'b0;
        finished = 1;
      end else if (out_valid) begin
        rdy = ($urandom_range(99) < rdy_pct);
        out_ready = rdy;
        saved = pack(out_x, out_y, out_last);
        if (rdy) begin
          if (idx < n) check("coord", saved, qc[idx]);
          else check("extra_coord", 1, 0);
          idx++;
        end
        hold = !rdy;
      end else begin
        out_ready = 1'b0;
        hold = 0;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
    @(negedge clk);
    check("pulse_one_cycle", {done, err, out_valid}, 0);
  endtask

  initial begin
    clear_grid();
    repeat (2) @(negedge clk);
    check("rst_outputs", {out_valid, out_last, busy, done, err}, 0);
    check("rst_coords", {rd_x, rd_y, out_x, out_y}, 0);
    rst = 1'b0;

    // Straight path west along row 0.
    clear_grid();
    for (int i = 0; i < 4; i++) begin dir_mem[0][i] = 3'd6; cost_mem[0][i] = 12'(2 * i); end
    run_walk(3, 0, 0, 0, 100, 0);
    run_walk(3, 0, 0, 0, 40, 0);   // backpressure
    run_walk(3, 0, 0, 0, 100, 1);  // start while busy is ignored

    // Diagonal NW.
    clear_grid();
    for (int i = 1; i < 5; i++) begin dir_mem[i][i] = 3'd7; cost_mem[i][i] = 12'(2 * (i - 1)); end
    run_walk(4, 4, 1, 1, 100, 0);

    // Unreachable goal.
    clear_grid();
    cost_mem[2][5] = 12'hFFF;
    run_walk(5, 2, 0, 0, 100, 0);

    // Two cells pointing at each other.
    clear_grid();
    dir_mem[3][2] = 3'd2; dir_mem[3][3] = 3'd6;
    run_walk(2, 3, 7, 7, 100, 0);

    // West off the grid edge.
    clear_grid();
    dir_mem[5][0] = 3'd6;
    run_walk(0, 5, 7, 7, 100, 0);

    // goal == src.
    run_walk(2, 2, 2, 2, 100, 0);

    // Reset during EMIT.
    clear_grid();
    for (int i = 0; i < 4; i++) begin dir_mem[0][i] = 3'd6; cost_mem[0][i] = 12'(2 * i); end
    @(negedge clk);
    goal_x = 3'd3; goal_y = 3'd0; src_x = 3'd0; src_y = 3'd0; start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("emit_before_rst", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {out_valid, out_last, busy, done, err}, 0);
    check("rst_mid_coords", {rd_x, rd_y, out_x, out_y}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_pulse", {done, err, busy}, 0);

    // Random fields.
    for (int t = 0; t < 30; t++) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          cost_mem[y][x] = ($urandom_range(11) == 0) ? 12'hFFF : 12'($urandom_range(200));
          dir_mem[y][x]  = 3'($urandom_range(7));
        end
      run_walk($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7),
               (t % 3 == 0) ? 100 : 30 + $urandom_range(60), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
